// File: rtl/aes_inv_round_engine.sv
// aes_inv_round_engine
//   Iterative AES decryption core. One inverse round per clock: InvShiftRows, InvSubBytes,
//   AddRoundKey, InvMixColumns (InvMixColumns skipped in the final round). Round keys are read
//   combinationally from an external key store addressed by key_idx.
//
//   Optional build macro: AES_DEC_FLUSH_EN adds a synchronous flush input that aborts the
//   current block and returns the engine to IDLE.
//
// Parameters
//   NR   number of rounds (10/12/14); the key store must hold NR+1 keys
//   KIW  width of key_idx
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   din/din_valid/din_ready   ciphertext input handshake; din[127:120] is byte 0
//   key_idx/kin           round-key index requested this cycle and the key returned for it
//   dout/dout_valid/dout_ready  plaintext output handshake, same byte order as din
//   flush                 (AES_DEC_FLUSH_EN only) abort to IDLE
//   busy                  high while a block is in flight (ROUND, FINAL, DONE)
module aes_inv_round_engine #(
  parameter int unsigned NR  = 10,
  parameter int unsigned KIW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [127:0]   din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [KIW-1:0] key_idx,
  input  logic [127:0]   kin,
  output logic [127:0]   dout,
  output logic           dout_valid,
  input  logic           dout_ready,
`ifdef AES_DEC_FLUSH_EN
  input  logic           flush,
`endif
  output logic           busy
);

  localparam logic [KIW-1:0] LastIdx  = KIW'(NR);
  localparam logic [KIW-1:0] FirstRnd = KIW'(NR - 1);

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  state_e         state_q;
  logic [127:0]   st_q;
  logic [KIW-1:0] rnd_q;
  logic           flush_req;
  logic [127:0]   sub_out;
  logic [127:0]   round_out;

  // ---------------------------------------------------------------------------------------------
  // GF(2^8) helpers, polynomial 0x11b
  // ---------------------------------------------------------------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // Byte k of the state sits at bits [127-8k -: 8]; column k/4, row k%4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8 * k -: 8] = InvSbox[s[127 - 8 * k -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      o[119 - 32 * c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      o[111 - 32 * c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      o[103 - 32 * c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Datapath: the final round shares the shift/sub/key-add stage with the middle rounds.
  // ---------------------------------------------------------------------------------------------
`ifdef AES_DEC_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign sub_out   = inv_sub_bytes(inv_shift_rows(st_q)) ^ kin;
  assign round_out = inv_mix_columns(sub_out);

  // rst_n is folded in so the engine refuses input while reset is held.
  assign din_ready = rst_n & (state_q == StIdle) & ~flush_req;
  assign busy      = (state_q != StIdle);

  always_comb begin
    key_idx = LastIdx;
    case (state_q)
      StRound: key_idx = rnd_q;
      StFinal: key_idx = '0;
      default: key_idx = LastIdx;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      st_q       <= '0;
      rnd_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush_req) begin
      // dout keeps its last value; only the valid flag is dropped.
      state_q    <= StIdle;
      rnd_q      <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (din_valid && din_ready) begin
            st_q    <= din ^ kin;
            rnd_q   <= FirstRnd;
            state_q <= StRound;
          end
        end
        StRound: begin
          st_q <= round_out;
          if (rnd_q == KIW'(1)) begin
            state_q <= StFinal;
          end else begin
            rnd_q <= rnd_q - KIW'(1);
          end
        end
        StFinal: begin
          dout       <= sub_out;
          dout_valid <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine. Expected plaintexts come from a forward AES cipher built here
// from first principles (S-box derived from GF inverses); the engine must invert it.
module tb_aes_inv_round_engine;
  localparam int unsigned NR  = 10;
  localparam int unsigned KIW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [127:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [KIW-1:0] key_idx;
  logic [127:0]   kin;
  logic [127:0]   dout;
  logic           dout_valid;
  logic           dout_ready = 1'b1;
  logic           busy;
  logic           flush_now;
`ifdef AES_DEC_FLUSH_EN
  logic           flush = 1'b0;
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  logic [127:0] rk [0:NR];
  logic [7:0]   sbox [256];
  assign kin = (int'(key_idx) <= NR) ? rk[key_idx] : '0;

  aes_inv_round_engine #(.NR(NR), .KIW(KIW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .key_idx    (key_idx),
    .kin        (kin),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
`ifdef AES_DEC_FLUSH_EN
    .flush      (flush),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      b = b >> 1;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} >> (8 - n);
    return d[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]] ^ rc, sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ rk[0][127 - 8 * k -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4 * c + w] = s[4 * ((c + w) % 4) + w];
      if (r != NR) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end
      end else begin
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++) s[k] ^= rk[r][127 - 8 * k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = s[k];
    return o;
  endfunction

  // ---------------- cycle-level expectation and compare process ----------------
  logic [127:0] din_pt = '0;   // plaintext the driver expects for the current din
  logic [127:0] exp_pt = '0;
  logic [127:0] pend_pt = '0;
  bit           active = 0, prev_in = 0, prev_out = 0, prev_flush = 0;
  int           cyc = 0;
  int           pcyc = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  always @(negedge clk) begin
    bit exp_ready, exp_valid;
    int exp_key;
    if (!rst_n) begin
      check("reset dout_valid", 128'(dout_valid), 128'd0);
      check("reset busy", 128'(busy), 128'd0);
      check("reset din_ready", 128'(din_ready), 128'd0);
      check("reset dout", dout, 128'd0);
      active = 0; prev_in = 0; prev_out = 0; prev_flush = 0; cyc = 0;
    end else begin
      if (prev_flush || prev_out) active = 0;
      else if (active) cyc++;
      if (prev_in) begin
        active = 1;
        cyc = 1;
        exp_pt = pend_pt;
      end
      exp_ready = !active && !flush_now;
      exp_valid = active && (cyc >= NR + 1);
      exp_key = (active && cyc <= NR) ? NR - cyc : NR;
      check("key_idx", 128'(key_idx), 128'(exp_key));
      check("busy", 128'(busy), 128'(active));
      check("din_ready", 128'(din_ready), 128'(exp_ready));
      check("dout_valid", 128'(dout_valid), 128'(exp_valid));
      if (exp_valid) check("dout", dout, exp_pt);
      prev_in = din_valid && exp_ready;
      pend_pt = din_pt;
      prev_out = exp_valid && dout_ready && !flush_now;
      prev_flush = flush_now;
    end
  end

  // ---------------- driver ----------------
  bit rand_ready = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int hs);
    int  n;
    bit  got;
    n = 0; got = 0; hs = 0;
    din = ct; din_pt = pt; din_valid = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (din_ready) begin got = 1; hs = pcyc; end
      tick();
      n++;
    end
    din_valid = 1'b0;
    din = rnd128();
    if (!got) check("handshake timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!dout_valid && n < 60) begin tick(); n++; end
    if (!dout_valid) check("dout_valid timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (dout_valid && n < 200) begin tick(); n++; end
    if (dout_valid) check("dout consume timeout", 128'd1, 128'd0);
  endtask

  initial begin
    logic [127:0] pt, pt2;
    int hs_a, hs_b;
    build_sbox();
    check("model sbox[00]", 128'(sbox[8'h00]), 128'h63);
    check("model sbox[53]", 128'(sbox[8'h53]), 128'hed);
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    check("model rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model fips ct", encrypt(128'h00112233445566778899aabbccddeeff),
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 through the engine; key_idx and latency checked every cycle
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, hs_a);
    wait_valid();
    check("fips dout", dout, 128'h00112233445566778899aabbccddeeff);
    wait_done();

    // backpressure with ignored din_valid pulses
    dout_ready = 1'b0;
    pt = rnd128();
    send(encrypt(pt), pt, hs_a);
    wait_valid();
    repeat (20) begin
      din_valid = 1'($urandom_range(0, 1));
      din = rnd128();
      tick();
    end
    check("held dout", dout, pt);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    tick();
    check("idle after release", 128'(din_ready), 128'd1);

    // back-to-back blocks
    pt = rnd128();
    pt2 = rnd128();
    send(encrypt(pt), pt, hs_a);
    send(encrypt(pt2), pt2, hs_b);
    check("back-to-back spacing", 128'(hs_b - hs_a), 128'(NR + 2));
    wait_valid();
    wait_done();

    // reset in the middle of a block
    pt = rnd128();
    send(encrypt(pt), pt, hs_a);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid reset dout_valid", 128'(dout_valid), 128'd0);
    check("mid reset busy", 128'(busy), 128'd0);
    check("mid reset din_ready", 128'(din_ready), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset din_ready", 128'(din_ready), 128'd1);
    pt = rnd128();
    send(encrypt(pt), pt, hs_a);
    wait_valid();
    check("post reset dout", dout, pt);
    wait_done();

`ifdef AES_DEC_FLUSH_EN
    pt = rnd128();
    send(encrypt(pt), pt, hs_a);
    repeat (2) tick();
    flush = 1'b1;
    din_valid = 1'b1;
    din = rnd128();
    tick();
    flush = 1'b0;
    din_valid = 1'b0;
    check("flush busy", 128'(busy), 128'd0);
    check("flush dout_valid", 128'(dout_valid), 128'd0);
    pt = rnd128();
    send(encrypt(pt), pt, hs_a);
    wait_valid();
    check("post flush dout", dout, pt);
    wait_done();
`endif

    // randomized keys, plaintexts, gaps and output backpressure
    rand_ready = 1;
    repeat (25) begin
      load_key(rnd128());
      pt = rnd128();
      repeat ($urandom_range(0, 3)) begin
        din = rnd128();
        tick();
      end
      send(encrypt(pt), pt, hs_a);
      wait_valid();
      wait_done();
    end
    rand_ready = 0;
    dout_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
